mux2_rr_arbiter: RTL and testbench
==================================

// Module: mux2_rr_arbiter
// PURPOSE
//  Round-robin arbiter and sequencer for a shared mux2 select tree: NREQ requesters
//  share one W-bit output path. Picks one requester, drives the tree select code
//  (SEL) and moves its beats through a one-entry output register using valid/ready
//  handshakes. A grant holds for multi-beat packets until LAST is accepted.
// PARAMETERS
//  NREQ  4  number of requesters (2..8)
//  W     8  data width per requester
//  SW    2  select code width, $clog2(NREQ), one bit per mux2 tree level
// PORTS
//  CLK        in   1        rising-edge clock, single clock domain
//  RST        in   1        synchronous reset, active-high
//  REQ_VALID  in   NREQ     requester i has a beat on REQ_DATA slice i
//  REQ_LAST   in   NREQ     beat from requester i is the last of its packet
//  REQ_DATA   in   NREQ*W   flattened data, requester i at [i*W +: W]
//  REQ_READY  out  NREQ     beat from requester i accepted this cycle
//  OUT_VALID  out  1        output register holds a beat
//  OUT_LAST   out  1        held beat is last of packet
//  OUT_DATA   out  W        held beat data
//  OUT_READY  in   1        downstream accepts the held beat
//  SEL        out  SW       select code of owning requester to the mux2 tree
//  BUSY       out  1        a packet grant is held (LOCKED state)
// BEHAVIOUR
//  - Reset (RST=1 at CLK edge): state IDLE, OUT_VALID=0, OUT_LAST=0, OUT_DATA=0,
//    SEL=0, BUSY=0, round-robin pointer PTR=0; REQ_READY=0 while RST=1.
//  - Output register: can_load = !OUT_VALID | OUT_READY. Load on accept; clear
//    OUT_VALID when OUT_READY=1 and no new accept in the same cycle. Latency: an
//    accepted beat is on OUT_* the following cycle. Full throughput 1 beat/cycle.
//  - State IDLE: winner = first i with REQ_VALID[i]=1 searching PTR, PTR+1, ... mod
//    NREQ. If any and can_load: REQ_READY[winner]=1, SEL<=winner, beat loaded;
//    if REQ_LAST[winner]=1 stay IDLE and PTR<=winner+1 mod NREQ, else go LOCKED.
//    Nothing requesting or !can_load: all REQ_READY=0, SEL and PTR hold.
//  - State LOCKED (BUSY=1): only requester SEL may be granted; REQ_READY[SEL] =
//    REQ_VALID[SEL] & can_load; other requesters stall regardless of VALID.
//    Accepted beat with LAST=1 -> IDLE, PTR<=SEL+1 mod NREQ. Gaps (VALID low)
//    keep the lock; no timeout.
//  - REQ_READY is combinational from state, PTR, REQ_VALID and OUT_READY; at most
//    one bit set per cycle. REQ_DATA/REQ_LAST sampled only on accept.
//  - SEL changes only on an accept in IDLE; stable through a whole packet.
//  - Backpressure: OUT_READY=0 with OUT_VALID=1 holds OUT_* stable, no accept.
//  - PTR wraps NREQ-1 -> 0; for NREQ not a power of 2, codes >= NREQ never issued.
//  - RST mid-packet: lock dropped, held beat discarded, next cycle as after reset.
// TESTING
//  - Reset: RST=1 two cycles with all REQ_VALID=1 -> REQ_READY=0, OUT_VALID=0,
//    SEL=0, BUSY=0; first cycle after release grants requester 0.
//  - Fairness: all 4 requesters single-beat (LAST=1) continuously, OUT_READY=1 ->
//    SEL sequence 0,1,2,3,0,... one beat per cycle, each OUT_DATA matches source.
//  - Packet lock: req1 sends 3 beats 0xA1,0xA2,0xA3(LAST) with req2 valid ->
//    req2 REQ_READY=0 until 0xA3 accepted; next grant req2, SEL 1 then 2.
//  - Backpressure: OUT_READY=0 for 3 cycles with OUT_VALID=1 -> OUT_DATA stable,
//    all REQ_READY=0; on OUT_READY=1 next beat loads same cycle, no bubble.
//  - Wrap/skip: PTR=3, only req3 and req0 valid -> req3 first, then req0; with
//    NREQ=3 SEL never reaches 3.
//  - Reset mid-packet: RST pulsed after 2nd beat of a 4-beat packet from req2 ->
//    BUSY=0, OUT_VALID=0 next cycle; grant restarts from requester 0.

Source files
------------

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter/sequencer for a shared mux2 select tree: one requester at a time
// owns the W-bit output register, and a multi-beat packet keeps its grant until LAST.
module mux2_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int SW   = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ-1:0]   req_last,
  input  logic [NREQ*W-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              out_valid,
  output logic              out_last,
  output logic [W-1:0]      out_data,
  input  logic              out_ready,
  output logic [SW-1:0]     sel,
  output logic              busy
);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t        state;
  logic [SW-1:0] ptr;
  logic [SW-1:0] winner;
  logic [SW-1:0] grant_idx;
  logic [SW:0]   cand;
  logic          any_req;
  logic          can_load;
  logic          accept;
  logic [W-1:0]  data_arr [NREQ];

  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("mux2_rr_arbiter: NREQ must be in 2..8");
  end

  for (genvar i = 0; i < NREQ; i++) begin : g_slice
    assign data_arr[i] = req_data[i*W +: W];
  end

  // Successor in round-robin order; codes >= NREQ are never produced.
  function automatic logic [SW-1:0] next_idx(input logic [SW-1:0] idx);
    if (int'(idx) == NREQ - 1) return '0;
    return idx + SW'(1);
  endfunction

  // Scan PTR, PTR+1, ... mod NREQ; the first valid requester wins.
  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    winner  = ptr;
    any_req = 1'b0;
    cand    = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = {1'b0, ptr} + (SW+1)'(i);
      if (cand >= (SW+1)'(NREQ)) cand = cand - (SW+1)'(NREQ);
      if (!any_req && req_valid[cand[SW-1:0]]) begin
        winner  = cand[SW-1:0];
        any_req = 1'b1;
      end
    end
  end

  assign can_load  = !out_valid || out_ready;
  assign grant_idx = (state == IDLE) ? winner : sel;

  // At most one ready bit: the winner when idle, the lock owner when locked.
  always_comb begin
    req_ready = '0;
    if (!rst && can_load) begin
      if (state == IDLE) begin
        if (any_req) req_ready[winner] = 1'b1;
      end else if (req_valid[sel]) begin
        req_ready[sel] = 1'b1;
      end
    end
  end

  assign accept = |req_ready;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      sel       <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        out_last  <= req_last[grant_idx];
        out_data  <= data_arr[grant_idx];
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (accept) begin
            sel <= winner;
            if (req_last[winner]) begin
              ptr <= next_idx(winner);
            end else begin
              state <= LOCKED;
              busy  <= 1'b1;
            end
          end
        end
        LOCKED: begin
          if (accept && req_last[sel]) begin
            state <= IDLE;
            busy  <= 1'b0;
            ptr   <= next_idx(sel);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Scoreboard bench for mux2_rr_arbiter: directed stimulus pushes expected beats,
// independent monitors pop and compare whenever a beat leaves the output register.
module tb_mux2_rr_arbiter;

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic [1:0] sel;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_last;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        out_valid;
  logic        out_last;
  logic [7:0]  out_data;
  logic        out_ready;
  logic [1:0]  sel;
  logic        busy;
  logic [7:0]  d [4];

  logic        rst3;
  logic [2:0]  v3;
  logic [2:0]  l3;
  logic [23:0] data3;
  logic [2:0]  ready3;
  logic        ov3;
  logic        ol3;
  logic [7:0]  od3;
  logic        or3;
  logic [1:0]  sel3;
  logic        busy3;

  exp_t q4[$];
  exp_t q3[$];
  int   checks = 0;
  int   errors = 0;

  assign req_data = {d[3], d[2], d[1], d[0]};

  mux2_rr_arbiter #(.NREQ(4), .W(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
    .req_ready(req_ready),
    .out_valid(out_valid), .out_last(out_last), .out_data(out_data),
    .out_ready(out_ready), .sel(sel), .busy(busy)
  );

  mux2_rr_arbiter #(.NREQ(3), .W(8)) dut3 (
    .clk(clk), .rst(rst3),
    .req_valid(v3), .req_last(l3), .req_data(data3),
    .req_ready(ready3),
    .out_valid(ov3), .out_last(ol3), .out_data(od3),
    .out_ready(or3), .sel(sel3), .busy(busy3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expect requester idx to be granted this cycle, record the beat, advance one clock.
  task automatic grant(input int idx, input logic [7:0] data, input logic last, input string name);
    #1;
    check(name, 32'(req_ready), 32'(1 << idx));
    q4.push_back('{data: data, last: last, sel: 2'(idx)});
    tick();
  endtask

  initial begin : monitor4
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (q4.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mon4_unexpected: got beat 0x%0h, expected no beat", out_data);
        end else begin
          e = q4.pop_front();
          check("mon4_data", 32'(out_data), 32'(e.data));
          check("mon4_last", 32'(out_last), 32'(e.last));
          check("mon4_sel", 32'(sel), 32'(e.sel));
        end
      end
    end
  end

  initial begin : monitor3
    exp_t e;
    forever begin
      @(negedge clk);
      if (ov3 && or3) begin
        if (q3.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mon3_unexpected: got beat 0x%0h, expected no beat", od3);
        end else begin
          e = q3.pop_front();
          check("mon3_data", 32'(od3), 32'(e.data));
          check("mon3_sel", 32'(sel3), 32'(e.sel));
        end
      end
    end
  end

  initial begin : stimulus
    rst       = 1'b1;
    rst3      = 1'b1;
    out_ready = 1'b1;
    or3       = 1'b1;
    req_valid = 4'b1111;
    req_last  = 4'b1111;
    d         = '{8'h10, 8'h11, 8'h12, 8'h13};
    v3        = 3'b111;
    l3        = 3'b111;
    data3     = {8'h62, 8'h61, 8'h60};

    // Reset held two cycles with everyone requesting.
    repeat (2) begin
      @(posedge clk);
      #2;
      check("rst_ready", 32'(req_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_sel", 32'(sel), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
    end
    rst = 1'b0;

    // Fairness: continuous single-beat requests rotate 0,1,2,3,0,...
    for (int k = 0; k < 8; k++) begin
      grant(k % 4, 8'h10 + 8'(k % 4), 1'b1, "fair_ready");
      check("fair_out_valid", 32'(out_valid), 32'd1);
    end
    req_valid = 4'b0000;
    tick();
    tick();
    check("fair_drained", 32'(out_valid), 32'd0);

    // Packet lock on req1 while req2 waits.
    req_valid = 4'b0110;
    req_last  = 4'b0100;
    d[1] = 8'hA1;
    d[2] = 8'hB2;
    grant(1, 8'hA1, 1'b0, "lock_first");
    check("lock_busy", 32'(busy), 32'd1);
    d[1] = 8'hA2;
    grant(1, 8'hA2, 1'b0, "lock_mid");
    req_valid = 4'b0100;
    #1;
    check("lock_gap_ready", 32'(req_ready), 32'd0);
    check("lock_gap_busy", 32'(busy), 32'd1);
    tick();
    req_valid = 4'b0110;
    req_last  = 4'b0110;
    d[1] = 8'hA3;
    grant(1, 8'hA3, 1'b1, "lock_last");
    check("unlock_busy", 32'(busy), 32'd0);
    req_valid = 4'b0100;
    grant(2, 8'hB2, 1'b1, "lock_next");
    req_valid = 4'b0000;
    tick();
    tick();

    // Backpressure with PTR=3.
    req_valid = 4'b1111;
    req_last  = 4'b1111;
    d = '{8'h40, 8'h41, 8'h42, 8'h43};
    grant(3, 8'h43, 1'b1, "bp_first");
    out_ready = 1'b0;
    repeat (3) begin
      #1;
      check("bp_ready", 32'(req_ready), 32'd0);
      check("bp_hold_data", 32'(out_data), 32'h43);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      tick();
    end
    out_ready = 1'b1;
    grant(0, 8'h40, 1'b1, "bp_resume");
    check("bp_no_bubble", 32'(out_data), 32'h40);
    req_valid = 4'b0000;
    tick();
    tick();

    // Wrap/skip: bring PTR to 3, then only req3 and req0 request.
    req_valid = 4'b0100;
    grant(2, 8'h42, 1'b1, "wrap_setup");
    req_valid = 4'b1001;
    grant(3, 8'h43, 1'b1, "wrap_first");
    grant(0, 8'h40, 1'b1, "wrap_second");
    req_valid = 4'b0000;
    tick();
    tick();

    // Reset after the 2nd beat of a 4-beat packet from req2; held beat is dropped.
    req_valid = 4'b0100;
    req_last  = 4'b0000;
    d[2] = 8'hC1;
    grant(2, 8'hC1, 1'b0, "mid_first");
    d[2] = 8'hC2;
    grant(2, 8'hC2, 1'b0, "mid_second");
    rst       = 1'b1;
    out_ready = 1'b0;
    d[2]      = 8'hC3;
    #1;
    check("mid_rst_ready", 32'(req_ready), 32'd0);
    tick();
    check("mid_held_beats", 32'(q4.size()), 32'd1);
    if (q4.size() > 0) void'(q4.pop_back());
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_out_valid", 32'(out_valid), 32'd0);
    check("mid_sel", 32'(sel), 32'd0);
    rst       = 1'b0;
    out_ready = 1'b1;
    req_valid = 4'b1111;
    req_last  = 4'b1111;
    d = '{8'h50, 8'h51, 8'h52, 8'h53};
    grant(0, 8'h50, 1'b1, "mid_restart");
    req_valid = 4'b0000;
    tick();
    tick();
    check("q4_empty", 32'(q4.size()), 32'd0);

    // NREQ=3 instance: rotation 0,1,2,0,... and code 3 never appears.
    rst3 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #1;
      check("n3_ready", 32'(ready3), 32'(1 << (k % 3)));
      q3.push_back('{data: 8'h60 + 8'(k % 3), last: 1'b1, sel: 2'(k % 3)});
      tick();
      check("n3_sel_range", 32'(sel3 < 2'd3), 32'd1);
    end
    v3 = 3'b000;
    tick();
    tick();
    check("q3_empty", 32'(q3.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
